dmi_jtag_dr_ctrl: RTL and testbench
===================================

Name: dmi_jtag_dr_ctrl

Overview:
- Sequences the DMIACCESS data register behind the JTAG TAP.
- Owns the 41-bit DMI shift register: 7-bit address, 32-bit data, 2-bit op.
- Converts update_dr events into single DMI requests with a valid/ready handshake, collects responses, and keeps the sticky dmistat error reported in DTMCS.
- Sits between the TAP and the DMI clock-domain crossing; runs entirely on tck_i.

Parameters:
- AddrWidth, 7, DMI address width; must match the abits value reported in DTMCS.
- DrWidth, AddrWidth+34, shift register length; derived, not overridable.

Ports:
- tck_i  in  1  JTAG clock
- trst_ni  in  1  asynchronous active-low reset
- test_logic_reset_i  in  1  TAP in Test-Logic-Reset (synchronous clear)
- dmi_access_i  in  1  IR selects DMIACCESS
- capture_dr_i  in  1  TAP CaptureDr state
- shift_dr_i  in  1  TAP ShiftDr state
- update_dr_i  in  1  TAP UpdateDr state
- dmi_tdi_i  in  1  serial data in
- dmi_tdo_o  out  1  serial data out (dr_q[0])
- dmi_reset_i  in  1  dtmcs.dmireset; clears sticky error
- dmi_error_o  out  2  sticky error to DTMCS dmistat
- dmi_req_valid_o  out  1  request valid
- dmi_req_ready_i  in  1  request accepted
- dmi_req_addr_o  out  AddrWidth  request address
- dmi_req_data_o  out  32  write data
- dmi_req_op_o  out  2  1=read, 2=write
- dmi_resp_valid_i  in  1  response valid
- dmi_resp_ready_o  out  1  response ready
- dmi_resp_data_i  in  32  read data
- dmi_resp_err_i  in  1  response failed

Behaviour:
- Reset (trst_ni low, asynchronous):
  - FSM=Idle; dr_q, address_q, data_q = 0; error_q=0 (NoError).
  - All outputs 0 except dmi_resp_ready_o=1.
- Error encoding: 0 NoError, 2 OpFailed, 3 Busy. Error is sticky: once nonzero it is changed only by dmi_reset_i or test_logic_reset_i.
- Shift register behaviour (all gated by dmi_access_i):
  - capture_dr: dr_d = {address_q, data_q, op_cap}. op_cap = 3 if FSM != Idle; otherwise op_cap = error_q.
  - capture_dr while FSM != Idle also sets error_q=3 if it was 0.
  - shift_dr: dr_d = {dmi_tdi_i, dr_q[DrWidth-1:1]}.
  - dmi_tdo_o = dr_q[0], combinational from the register; the TAP retimes it on the falling edge.
- FSM states: Idle, Read, WaitReadValid, Write, WaitWriteValid.
- Idle:
  - On update_dr & dmi_access_i & error_q==0, latch address_q and data_q from the dr_q fields.
  - op==1: go to Read. op==2: go to Write. op==0 or 3: no request, stay Idle.
  - If error_q != 0, update_dr is ignored entirely (no latch, no request).
- Read / Write:
  - dmi_req_valid_o=1; addr, data and op are driven from the latched registers (op 1 for Read, 2 for Write).
  - On dmi_req_ready_i, go to WaitReadValid / WaitWriteValid the next cycle.
  - valid must stay high and payload stable until ready is seen.
- WaitReadValid / WaitWriteValid:
  - dmi_resp_ready_o=1.
  - On dmi_resp_valid_i, go to Idle. WaitReadValid also loads data_q = dmi_resp_data_i.
  - If dmi_resp_err_i is set, error_q=2, unless error_q is already nonzero.
  - A write response never modifies data_q.
- update_dr while FSM != Idle: error_q=3 if it was 0; no new request; latched fields unchanged.
- dmi_reset_i: error_q=0 the next cycle. If busy is detected in the same cycle, the clear wins.
- test_logic_reset_i:
  - Clears dr_q and error_q.
  - FSM returns to Idle from any state; an unaccepted request is dropped.
  - Responses arriving in Idle are accepted and discarded.
- Simultaneous req_valid & req_ready in the same cycle the FSM enters Read: the handshake completes in that cycle. Minimum request-to-response latency is 1 cycle.
- dmi_error_o = error_q (registered, no combinational path from inputs).
- Capture, shift and update are mutually exclusive (TAP guarantee). No assertion is required, but priority is test_logic_reset > update > shift > capture.

Test Plan:
- Read: shift {addr=0x11, data=0, op=1}, update; ready held 1, response data 0xDEADBEEF after 2 cycles. Required: one req pulse with addr 0x11, op 1; next capture shifts out {0x11, 0xDEADBEEF, 0}.
- Write: shift {0x04, 0x12345678, op=2}; ready delayed 3 cycles. Required: valid held 3 cycles with stable payload; data_q unchanged by the response.
- Busy: issue a read, then capture+update before the response arrives. Required: captured op=3, error_o=3, no second request; sticky until dmi_reset_i pulse, then error_o=0.
- Failure: response with err=1. Required: error_o=2. Subsequent updates with op=1 issue no request until dmi_reset_i.
- Reset mid-op: assert test_logic_reset_i while in Read with ready=0. Required: valid drops the next cycle, FSM Idle, error_o=0. Also assert trst_ni low asynchronously and check all outputs at reset values.
- Nop: update with op=0. Required: no request, error unchanged, and capture returns the previous address/data.

Source files
------------

// File: rtl/dmi_jtag_dr_ctrl.sv
// DMIACCESS data-register sequencer: owns the 41-bit DMI shift register, turns
// UpdateDr events into DMI requests and tracks the sticky dmistat error on tck_i.
module dmi_jtag_dr_ctrl #(
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 test_logic_reset_i,
  input  logic                 dmi_access_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_tdi_i,
  output logic                 dmi_tdo_o,
  input  logic                 dmi_reset_i,
  output logic [1:0]           dmi_error_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic                 dmi_resp_err_i
);

  localparam int unsigned DrWidth = AddrWidth + 34;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    WAIT_READ  = 3'd2,
    WRITE      = 3'd3,
    WAIT_WRITE = 3'd4
  } state_e;

  state_e               state_r, state_s;
  logic [DrWidth-1:0]   dr_r, dr_s;
  logic [AddrWidth-1:0] address_r, address_s;
  logic [31:0]          data_r, data_s;
  logic [1:0]           error_r, error_s;
  logic                 busy_s, dr_update_s, dr_shift_s, dr_capture_s;
  logic                 busy_hit_s, fail_hit_s;

  // TAP phases are exclusive in practice; enforce update > shift > capture anyway.
  assign busy_s       = (state_r != IDLE);
  assign dr_update_s  = dmi_access_i & update_dr_i;
  assign dr_shift_s   = dmi_access_i & shift_dr_i & ~update_dr_i;
  assign dr_capture_s = dmi_access_i & capture_dr_i & ~update_dr_i & ~shift_dr_i;
  assign busy_hit_s   = busy_s & (dr_update_s | dr_capture_s);
  assign fail_hit_s   = dmi_resp_valid_i & dmi_resp_err_i &
                        ((state_r == WAIT_READ) | (state_r == WAIT_WRITE));

  // Request/response sequencing and latching of the request payload.
  always_comb begin
    state_s   = state_r;
    address_s = address_r;
    data_s    = data_r;
    if (test_logic_reset_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (dr_update_s && (error_r == 2'd0)) begin
            address_s = dr_r[DrWidth-1 -: AddrWidth];
            data_s    = dr_r[33:2];
            case (dr_r[1:0])
              2'd1:    state_s = READ;
              2'd2:    state_s = WRITE;
              default: state_s = IDLE;
            endcase
          end else begin
            state_s = IDLE;
          end
        end
        READ:  state_s = dmi_req_ready_i ? WAIT_READ : READ;
        WRITE: state_s = dmi_req_ready_i ? WAIT_WRITE : WRITE;
        WAIT_READ: begin
          if (dmi_resp_valid_i) begin
            state_s = IDLE;
            data_s  = dmi_resp_data_i;
          end else begin
            state_s = WAIT_READ;
          end
        end
        WAIT_WRITE: state_s = dmi_resp_valid_i ? IDLE : WAIT_WRITE;
        default:    state_s = IDLE;
      endcase
    end
  end

  // Shift register: capture reports Busy in the op field while a request is in flight.
  always_comb begin
    dr_s = dr_r;
    if (test_logic_reset_i) begin
      dr_s = '0;
    end else if (dr_shift_s) begin
      dr_s = {dmi_tdi_i, dr_r[DrWidth-1:1]};
    end else if (dr_capture_s) begin
      dr_s = {address_r, data_r, (busy_s ? 2'd3 : error_r)};
    end else begin
      dr_s = dr_r;
    end
  end

  // Sticky error: first error wins, only the two clears can lower it.
  always_comb begin
    error_s = error_r;
    if (test_logic_reset_i || dmi_reset_i) begin
      error_s = 2'd0;
    end else if (error_r != 2'd0) begin
      error_s = error_r;
    end else if (busy_hit_s) begin
      error_s = 2'd3;
    end else if (fail_hit_s) begin
      error_s = 2'd2;
    end else begin
      error_s = 2'd0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_r   <= IDLE;
      dr_r      <= '0;
      address_r <= '0;
      data_r    <= 32'd0;
      error_r   <= 2'd0;
    end else begin
      state_r   <= state_s;
      dr_r      <= dr_s;
      address_r <= address_s;
      data_r    <= data_s;
      error_r   <= error_s;
    end
  end

  // Request op decoded from the state register only.
  always_comb begin
    case (state_r)
      READ:    dmi_req_op_o = 2'd1;
      WRITE:   dmi_req_op_o = 2'd2;
      default: dmi_req_op_o = 2'd0;
    endcase
  end

  assign dmi_req_valid_o  = (state_r == READ) || (state_r == WRITE);
  assign dmi_resp_ready_o = ~dmi_req_valid_o;
  assign dmi_req_addr_o   = address_r;
  assign dmi_req_data_o   = data_r;
  assign dmi_error_o      = error_r;
  assign dmi_tdo_o        = dr_r[0];

endmodule

// File: tb/tb_dmi_jtag_dr_ctrl.sv
// Bench for dmi_jtag_dr_ctrl: directed scenarios with literal expectations plus
// randomized TAP/DMI traffic compared every cycle against a transaction-level model.
module tb_dmi_jtag_dr_ctrl;

  logic        tck_i = 1'b0;
  logic        trst_ni, test_logic_reset_i, dmi_access_i;
  logic        capture_dr_i, shift_dr_i, update_dr_i, dmi_tdi_i, dmi_tdo_o;
  logic        dmi_reset_i;
  logic [1:0]  dmi_error_o;
  logic        dmi_req_valid_o, dmi_req_ready_i;
  logic [6:0]  dmi_req_addr_o;
  logic [31:0] dmi_req_data_o;
  logic [1:0]  dmi_req_op_o;
  logic        dmi_resp_valid_i, dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i;
  logic        dmi_resp_err_i;

  dmi_jtag_dr_ctrl #(.AddrWidth(7)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .test_logic_reset_i(test_logic_reset_i),
    .dmi_access_i(dmi_access_i), .capture_dr_i(capture_dr_i), .shift_dr_i(shift_dr_i),
    .update_dr_i(update_dr_i), .dmi_tdi_i(dmi_tdi_i), .dmi_tdo_o(dmi_tdo_o),
    .dmi_reset_i(dmi_reset_i), .dmi_error_o(dmi_error_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_data_o(dmi_req_data_o),
    .dmi_req_op_o(dmi_req_op_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
    .dmi_resp_err_i(dmi_resp_err_i)
  );

  always #5 tck_i = ~tck_i;

  int n_cmp = 0;
  int n_err = 0;
  int dut_hs = 0;
  int m_hs = 0;

  // Transaction-level model: phase 0 = no transaction, 1 = request offered, 2 = awaiting response.
  logic [40:0] m_dr;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_err;
  logic [1:0]  m_kind;
  int          m_phase;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dr = '0; m_addr = '0; m_data = '0; m_err = '0; m_kind = '0; m_phase = 0;
  endtask

  task automatic model_step();
    logic [40:0] dr_n;
    logic [31:0] data_n;
    logic [6:0]  addr_n;
    int          phase_n;
    logic        busy_hit, fail_hit;
    if (m_phase == 1 && dmi_req_ready_i) m_hs++;
    if (test_logic_reset_i) begin
      m_dr = '0; m_err = 2'd0; m_phase = 0;
      return;
    end
    dr_n = m_dr; data_n = m_data; addr_n = m_addr; phase_n = m_phase;
    busy_hit = 1'b0; fail_hit = 1'b0;
    if (m_phase == 1 && dmi_req_ready_i) phase_n = 2;
    if (m_phase == 2 && dmi_resp_valid_i) begin
      phase_n = 0;
      if (m_kind == 2'd1) data_n = dmi_resp_data_i;
      fail_hit = dmi_resp_err_i;
    end
    if (dmi_access_i) begin
      if (update_dr_i) begin
        if (m_phase != 0) busy_hit = 1'b1;
        else if (m_err == 2'd0) begin
          addr_n = m_dr[40:34];
          data_n = m_dr[33:2];
          if (m_dr[1:0] == 2'd1 || m_dr[1:0] == 2'd2) begin
            phase_n = 1;
            m_kind  = m_dr[1:0];
          end
        end
      end else if (shift_dr_i) begin
        dr_n = {dmi_tdi_i, m_dr[40:1]};
      end else if (capture_dr_i) begin
        dr_n = {m_addr, m_data, (m_phase != 0) ? 2'd3 : m_err};
        if (m_phase != 0) busy_hit = 1'b1;
      end
    end
    if (m_err == 2'd0) m_err = busy_hit ? 2'd3 : (fail_hit ? 2'd2 : 2'd0);
    if (dmi_reset_i) m_err = 2'd0;
    m_dr = dr_n; m_data = data_n; m_addr = addr_n; m_phase = phase_n;
  endtask

  task automatic check_all();
    check("tdo", dmi_tdo_o, m_dr[0]);
    check("error", dmi_error_o, m_err);
    check("req_valid", dmi_req_valid_o, m_phase == 1);
    check("req_addr", dmi_req_addr_o, m_addr);
    check("req_data", dmi_req_data_o, m_data);
    check("req_op", dmi_req_op_o, (m_phase == 1) ? m_kind : 2'd0);
    check("resp_ready", dmi_resp_ready_o, m_phase != 1);
  endtask

  task automatic tick();
    if (dmi_req_valid_o && dmi_req_ready_i) dut_hs++;
    @(posedge tck_i);
    model_step();
    @(negedge tck_i);
    check_all();
  endtask

  task automatic shift_frame(input logic [40:0] din, output logic [40:0] dout);
    for (int i = 0; i < 41; i++) begin
      dout[i]    = dmi_tdo_o;
      dmi_tdi_i  = din[i];
      shift_dr_i = 1'b1;
      tick();
    end
    shift_dr_i = 1'b0;
    dmi_tdi_i  = 1'b0;
  endtask

  task automatic send_frame(input logic [40:0] din);
    logic [40:0] unused;
    shift_frame(din, unused);
    update_dr_i = 1'b1;
    tick();
    update_dr_i = 1'b0;
  endtask

  task automatic read_back(output logic [40:0] dout);
    capture_dr_i = 1'b1;
    tick();
    capture_dr_i = 1'b0;
    shift_frame(41'd0, dout);
  endtask

  logic [40:0] f;
  int          hs0, r;

  initial begin
    trst_ni = 1'b0; test_logic_reset_i = 1'b0; dmi_access_i = 1'b1;
    capture_dr_i = 1'b0; shift_dr_i = 1'b0; update_dr_i = 1'b0; dmi_tdi_i = 1'b0;
    dmi_reset_i = 1'b0; dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i = 32'd0; dmi_resp_err_i = 1'b0;
    model_reset();
    #12;
    check("rst_valid", dmi_req_valid_o, 1'b0);
    check("rst_resp_ready", dmi_resp_ready_o, 1'b1);
    check("rst_error", dmi_error_o, 2'd0);
    check("rst_op", dmi_req_op_o, 2'd0);
    @(negedge tck_i);
    trst_ni = 1'b1;

    // Read
    dmi_req_ready_i = 1'b1;
    hs0 = dut_hs;
    send_frame({7'h11, 32'h0, 2'd1});
    check("read_valid", dmi_req_valid_o, 1'b1);
    check("read_addr", dmi_req_addr_o, 7'h11);
    check("read_op", dmi_req_op_o, 2'd1);
    tick();
    check("read_valid_drop", dmi_req_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hDEADBEEF;
    tick();
    dmi_resp_valid_i = 1'b0;
    check("read_hs_count", dut_hs - hs0, 1);
    read_back(f);
    check("read_capture", f, {7'h11, 32'hDEADBEEF, 2'd0});

    // Write with delayed ready
    dmi_req_ready_i = 1'b0;
    send_frame({7'h04, 32'h12345678, 2'd2});
    for (int k = 0; k < 3; k++) begin
      check("write_valid_held", dmi_req_valid_o, 1'b1);
      check("write_addr", dmi_req_addr_o, 7'h04);
      check("write_data", dmi_req_data_o, 32'h12345678);
      check("write_op", dmi_req_op_o, 2'd2);
      if (k == 2) dmi_req_ready_i = 1'b1;
      tick();
    end
    dmi_req_ready_i = 1'b0;
    check("write_valid_drop", dmi_req_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hFFFFFFFF;
    tick();
    dmi_resp_valid_i = 1'b0;
    read_back(f);
    check("write_capture", f, {7'h04, 32'h12345678, 2'd0});

    // Busy
    dmi_req_ready_i = 1'b1;
    hs0 = dut_hs;
    send_frame({7'h22, 32'h0, 2'd1});
    tick();
    read_back(f);
    check("busy_capture", f, {7'h22, 32'h0, 2'd3});
    check("busy_error", dmi_error_o, 2'd3);
    shift_frame({7'h33, 32'h0, 2'd1}, f);
    update_dr_i = 1'b1;
    tick();
    update_dr_i = 1'b0;
    check("busy_no_req", dmi_req_valid_o, 1'b0);
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hAAAA5555;
    tick();
    dmi_resp_valid_i = 1'b0;
    send_frame({7'h33, 32'h0, 2'd1});
    check("busy_sticky_no_req", dmi_req_valid_o, 1'b0);
    check("busy_sticky", dmi_error_o, 2'd3);
    check("busy_hs_count", dut_hs - hs0, 1);
    dmi_reset_i = 1'b1;
    tick();
    dmi_reset_i = 1'b0;
    check("busy_cleared", dmi_error_o, 2'd0);

    // Failure
    send_frame({7'h05, 32'h0, 2'd1});
    tick();
    dmi_resp_valid_i = 1'b1; dmi_resp_err_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0; dmi_resp_err_i = 1'b0;
    check("fail_error", dmi_error_o, 2'd2);
    send_frame({7'h05, 32'h0, 2'd1});
    check("fail_no_req", dmi_req_valid_o, 1'b0);
    dmi_reset_i = 1'b1;
    tick();
    dmi_reset_i = 1'b0;
    check("fail_cleared", dmi_error_o, 2'd0);

    // Test-Logic-Reset mid request
    dmi_req_ready_i = 1'b0;
    send_frame({7'h06, 32'h0, 2'd1});
    check("tlr_pre_valid", dmi_req_valid_o, 1'b1);
    test_logic_reset_i = 1'b1;
    tick();
    test_logic_reset_i = 1'b0;
    check("tlr_valid", dmi_req_valid_o, 1'b0);
    check("tlr_error", dmi_error_o, 2'd0);
    check("tlr_resp_ready", dmi_resp_ready_o, 1'b1);

    // Nop keeps the previous address/data
    dmi_req_ready_i = 1'b1;
    send_frame({7'h06, 32'h0, 2'd1});
    tick();
    dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h0BADF00D;
    tick();
    dmi_resp_valid_i = 1'b0;
    send_frame({7'h06, 32'h0BADF00D, 2'd0});
    check("nop_no_req", dmi_req_valid_o, 1'b0);
    check("nop_error", dmi_error_o, 2'd0);
    read_back(f);
    check("nop_capture", f, {7'h06, 32'h0BADF00D, 2'd0});

    // Asynchronous reset with a request pending
    dmi_req_ready_i = 1'b0;
    send_frame({7'h09, 32'h55AA55AA, 2'd2});
    #2 trst_ni = 1'b0;
    #1;
    model_reset();
    check("arst_valid", dmi_req_valid_o, 1'b0);
    check("arst_resp_ready", dmi_resp_ready_o, 1'b1);
    check("arst_addr", dmi_req_addr_o, 7'h00);
    check("arst_data", dmi_req_data_o, 32'h0);
    check("arst_op", dmi_req_op_o, 2'd0);
    check("arst_tdo", dmi_tdo_o, 1'b0);
    @(negedge tck_i);
    trst_ni = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(9, 0);
      dmi_access_i       = ($urandom_range(9, 0) != 0);
      shift_dr_i         = (r < 6);
      capture_dr_i       = (r == 6);
      update_dr_i        = (r == 7);
      dmi_tdi_i          = $urandom_range(1, 0) != 0;
      dmi_req_ready_i    = $urandom_range(1, 0) != 0;
      dmi_resp_valid_i   = ($urandom_range(2, 0) == 0);
      dmi_resp_err_i     = ($urandom_range(7, 0) == 0);
      dmi_resp_data_i    = $urandom;
      dmi_reset_i        = ($urandom_range(39, 0) == 0);
      test_logic_reset_i = ($urandom_range(99, 0) == 0);
      tick();
    end
    shift_dr_i = 1'b0; capture_dr_i = 1'b0; update_dr_i = 1'b0;
    dmi_resp_valid_i = 1'b0; dmi_reset_i = 1'b0; test_logic_reset_i = 1'b0;
    check("hs_total", dut_hs, m_hs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
